fountain_v1_sched: RTL and testbench
====================================

# fountain_v1_sched

Two-requester scheduler that shares one `fountain_v1_serial` core. It arbitrates 64-bit jobs round-robin and sequences the core's `start`/`data_in`. Because the core has no done flag, the scheduler counts a fixed latency and then returns the captured `data_out` with the requester's id over a valid/ready response port. It sits directly in front of the serial core and owns its control inputs exclusively.

## Interface
- `DW`, 64: data word width, matching the core's `data_in`/`data_out`.
- `START_LEN`, 1: cycles `core_start` is held high per job (≥1).
- `CORE_LAT`, 32: cycles from the last `core_start` cycle until `core_data_out` is valid (≥1).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` / `req1_valid` in 1: requester has a job.
- `req0_ready` / `req1_ready` out 1: job accepted when valid & ready.
- `req0_data` / `req1_data` in DW: job input word.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_id` out 1: requester index of the result.
- `rsp_data` out DW: captured core output.
- `core_start` out 1: drives the core's `start`.
- `core_data_in` out DW: drives the core's `data_in`.
- `core_data_out` in DW: the core's `data_out`.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE → START → WAIT → RESP → IDLE.
- **IDLE:** the grant goes to the single valid requester. If both are valid, the grant goes to the requester selected by the round-robin pointer `rr`.
  - `reqN_ready` is high only for the granted requester. This is a combinational path from valid to ready.
  - On handshake: latch the data into `job_data` and the id into `job_id`, then go to START.
- **START:** `core_start` = 1 for exactly START_LEN cycles, then go to WAIT with the counter cleared.
- **WAIT:** the counter increments each cycle. In the cycle where counter == CORE_LAT-1, register `core_data_out` into `rsp_data` and go to RESP.
  - The counter is $clog2(CORE_LAT+1) bits wide.
  - There is no wrap-around; the counter is cleared on entry to WAIT.
- **RESP:** `rsp_valid` = 1, with `rsp_id` = `job_id`. `rsp_valid` and `rsp_data` are held stable until `rsp_ready`.
  - On handshake: set `rr` to the requester other than `job_id`, then go to IDLE.
- `core_data_in` = `job_data` from START through RESP. It stays unchanged even if `reqN_data` changes.
- No request is accepted outside IDLE. All `reqN_ready` = 0 in START, WAIT and RESP.
- A requester that drops valid before the handshake is not an error; the grant is re-evaluated every IDLE cycle.
- The core itself has no reset. Each new `core_start` re-initialises it, so no core flush is needed.

## Timing
- **Reset values:** state IDLE, `rr` = 0 (requester 0 favoured), counter 0. Outputs: `core_start` 0, `core_data_in` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_data` 0, `busy` 0.
- **rst in any state:** at the next edge the block is in IDLE with all reset values applied. An in-flight job is dropped with no response.
- **Latency:** request handshake at cycle T.
  - `core_start` is high in T+1 … T+START_LEN.
  - Capture happens at the end of cycle T+START_LEN+CORE_LAT.
  - `rsp_valid` rises in cycle T+START_LEN+CORE_LAT+1.
- **Throughput:** with `rsp_ready` tied high, at most one job per START_LEN+CORE_LAT+2 cycles.
- **Back-pressure:** `rsp_valid` high with `rsp_ready` low stalls the FSM in RESP indefinitely.
- **Simultaneous valid:** the `rr` pointer breaks the tie. Persistent valids on both inputs produce strict alternation.

## Structure
- Shared definitions file `fountain_v1_defs.vh`: FSM state encodings (IDLE=0, START=1, WAIT=2, RESP=3), default DW, START_LEN and CORE_LAT constants.
- One sub-module, `rr_arb2`: a two-input round-robin grant. Inputs are the two valids and `rr`; outputs are a one-hot grant and the grant id. It is purely combinational.
- The top level holds the FSM, counter, job registers and response registers.

## Test plan
All scenarios use DW=64, START_LEN=1, CORE_LAT=32. The core is modelled by a stub that drives `data_out` = ~`data_in`, valid 32 cycles after `start` falls.

1. **Single job:** `req0_valid` with `0x5555_5555_5555_5555`, handshake at T.
   - `core_start` is high only in T+1.
   - `rsp_valid` is high at T+34 with `rsp_id` = 0 and `rsp_data` = `0xAAAA_AAAA_AAAA_AAAA`.
2. **Simultaneous valid after reset:** both requests valid, req0 = `0x1`, req1 = `0x2`.
   - req0 is granted first; responses arrive as id 0 with `~0x1`, then id 1 with `~0x2`.
3. **Persistent contention:** both valids held high for 6 jobs, `rsp_ready` = 1.
   - Ids alternate 0,1,0,1,0,1.
   - Handshakes are spaced exactly 35 cycles apart.
4. **Response stall:** `rsp_ready` = 0 for 5 cycles in RESP.
   - `rsp_valid`, `rsp_id` and `rsp_data` stay stable.
   - Both `reqN_ready` stay 0; completion follows on the first `rsp_ready` = 1.
5. **Reset mid-job:** `rst` pulsed at WAIT counter = 10.
   - The next cycle shows all reset values, and no response is ever emitted for that job.
   - A following req1 job with `0xFF` completes normally with `~0xFF`.
6. **Input change after accept:** `req0_data` changes from `0x3` to `0x4` in the cycle after the handshake.
   - `core_data_in` remains `0x3` through RESP.

Source files
------------

// File: rtl/fountain_v1_sched_pkg.sv
// Shared definitions for the fountain_v1 scheduler: FSM encoding and default sizing.
// The state values are fixed so the encoding stays stable in waveforms and debug taps.
package fountain_v1_sched_pkg;

    localparam int DEF_DW        = 64;
    localparam int DEF_START_LEN = 1;
    localparam int DEF_CORE_LAT  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fountain_v1_sched_rr_arb2.sv
// Two-input round-robin grant: a lone valid always wins; a tie goes to the side chosen by rr.
// Purely combinational, no state of its own.
module rr_arb2 (
    input  logic       i_vld0,
    input  logic       i_vld1,
    input  logic       i_rr,
    output logic [1:0] o_gnt,
    output logic       o_gid
);

    always_comb begin
        o_gid = (i_vld0 && i_vld1) ? i_rr : i_vld1;
        o_gnt = {i_vld1 & o_gid, i_vld0 & ~o_gid};
    end

endmodule

// File: rtl/fountain_v1_sched.sv
// Shares one fountain_v1_serial core between two requesters: arbitrate, pulse start, count the
// fixed core latency, capture data_out, then hold the result on rsp_* until rsp_ready.
module fountain_v1_sched
    import fountain_v1_sched_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int START_LEN = DEF_START_LEN,
    parameter int CORE_LAT  = DEF_CORE_LAT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
    output logic          core_start,
    output logic [DW-1:0] core_data_in,
    input  logic [DW-1:0] core_data_out,
    output logic          busy
);

    // One counter serves both the START hold and the WAIT latency count.
    localparam int CW = $clog2(max2(CORE_LAT, START_LEN) + 1);

    state_t          r_state;
    state_t          w_next;
    logic            r_rr;
    logic            r_job_id;
    logic [DW-1:0]   r_job_data;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_rsp_data;
    logic [1:0]      w_gnt;
    logic            w_gid;
    logic            w_start_last;
    logic            w_wait_last;

    rr_arb2 u_arb (
        .i_vld0 (req0_valid),
        .i_vld1 (req1_valid),
        .i_rr   (r_rr),
        .o_gnt  (w_gnt),
        .o_gid  (w_gid)
    );

    assign w_start_last = (r_cnt == CW'(START_LEN - 1));
    assign w_wait_last  = (r_cnt == CW'(CORE_LAT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (|w_gnt)       w_next = ST_START;
            ST_START: if (w_start_last) w_next = ST_WAIT;
            ST_WAIT:  if (w_wait_last)  w_next = ST_RESP;
            ST_RESP:  if (rsp_ready)    w_next = ST_IDLE;
            default:                    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rr       <= 1'b0;
            r_job_id   <= 1'b0;
            r_job_data <= '0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (|w_gnt) begin
                        r_job_data <= w_gnt[1] ? req1_data : req0_data;
                        r_job_id   <= w_gid;
                        r_cnt      <= '0;
                    end
                end
                ST_START: r_cnt <= w_start_last ? '0 : r_cnt + 1'b1;
                ST_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_wait_last) r_rsp_data <= core_data_out;
                end
                ST_RESP: if (rsp_ready) r_rr <= ~r_job_id;
                default: r_cnt <= '0;
            endcase
        end
    end

    assign req0_ready   = (r_state == ST_IDLE) & w_gnt[0];
    assign req1_ready   = (r_state == ST_IDLE) & w_gnt[1];
    assign core_start   = (r_state == ST_START);
    // job_data only moves on a handshake, so the core input is stable for the whole job.
    assign core_data_in = r_job_data;
    assign rsp_valid    = (r_state == ST_RESP);
    assign rsp_id       = r_job_id;
    assign rsp_data     = r_rsp_data;
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fountain_v1_sched.sv
// Directed bench for fountain_v1_sched with a core stub returning ~data_in 32 cycles after start.
module tb_fountain_v1_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [63:0] req0_data, req1_data;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [63:0] rsp_data, core_data_in, core_data_out;
    logic        core_start, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fountain_v1_sched #(.DW(64), .START_LEN(1), .CORE_LAT(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_data     (req0_data),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_data     (req1_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .core_start    (core_start),
        .core_data_in  (core_data_in),
        .core_data_out (core_data_out),
        .busy          (busy)
    );

    // Core stub: output is garbage until 32 cycles after start falls.
    logic [63:0] stub_d = 64'h0;
    int          stub_cnt = 1000;
    always @(posedge clk) begin
        if (core_start) begin
            stub_d   <= core_data_in;
            stub_cnt <= 0;
        end else if (stub_cnt < 1000) begin
            stub_cnt <= stub_cnt + 1;
        end
    end
    assign core_data_out = (stub_cnt >= 31) ? ~stub_d : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string tag, input logic id, input logic [63:0] data);
        chk({tag, "_vld"}, rsp_valid, 1);
        chk({tag, "_id"}, rsp_id, id);
        chk({tag, "_dat"}, rsp_data, data);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_start"}, core_start, 0);
        chk({tag, "_din"}, core_data_in, 0);
        chk({tag, "_rspv"}, rsp_valid, 0);
        chk({tag, "_rspid"}, rsp_id, 0);
        chk({tag, "_rspd"}, rsp_data, 0);
    endtask

    logic seen;

    initial begin
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_data = '0; req1_data = '0;
        rsp_ready = 0;
        tick(); tick();
        rst = 1'b0;
        chk_reset_vals("reset");

        // Single job, exact start/response timing
        req0_valid = 1; req0_data = 64'h5555_5555_5555_5555;
        #1;
        chk("t1_rdy0", req0_ready, 1);
        chk("t1_rdy1", req1_ready, 0);
        tick();                               // T+1
        req0_valid = 0;
        #1;
        chk("t1_start_hi", core_start, 1);
        chk("t1_din", core_data_in, 64'h5555_5555_5555_5555);
        tick();                               // T+2
        chk("t1_start_lo", core_start, 0);
        chk("t1_busy", busy, 1);
        repeat (31) tick();                   // T+33
        chk("t1_early", rsp_valid, 0);
        tick();                               // T+34
        chk_rsp("t1_rsp", 0, 64'hAAAA_AAAA_AAAA_AAAA);
        rsp_ready = 1;
        tick();
        chk("t1_done_vld", rsp_valid, 0);
        chk("t1_done_busy", busy, 0);

        // Simultaneous valid after reset: req0 first
        rst = 1; tick(); rst = 0;
        req0_valid = 1; req0_data = 64'h1;
        req1_valid = 1; req1_data = 64'h2;
        #1;
        chk("t2_rdy0", req0_ready, 1);
        chk("t2_rdy1", req1_ready, 0);
        tick();
        req0_valid = 0;
        repeat (33) tick();
        chk_rsp("t2_rsp0", 0, ~64'h1);
        tick();
        chk("t2_rdy1b", req1_ready, 1);
        tick();
        req1_valid = 0;
        repeat (33) tick();
        chk_rsp("t2_rsp1", 1, ~64'h2);
        tick();

        // Persistent contention: strict alternation at 35-cycle spacing
        rst = 1; tick(); rst = 0;
        req0_valid = 1; req0_data = 64'h10;
        req1_valid = 1; req1_data = 64'h20;
        #1;
        for (int j = 0; j < 6; j++) begin
            chk("t3_rdy0", req0_ready, (j % 2 == 0) ? 1 : 0);
            chk("t3_rdy1", req1_ready, (j % 2 == 1) ? 1 : 0);
            repeat (34) tick();
            chk_rsp("t3_rsp", j[0], (j % 2 == 0) ? ~64'h10 : ~64'h20);
            tick();
        end

        // Response stall with both requesters still pending
        rsp_ready = 0;
        chk("t4_rdy0", req0_ready, 1);
        repeat (34) tick();
        chk_rsp("t4_rsp", 0, ~64'h10);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_rsp("t4_hold", 0, ~64'h10);
            chk("t4_rdy0_lo", req0_ready, 0);
            chk("t4_rdy1_lo", req1_ready, 0);
        end
        rsp_ready = 1;
        tick();
        chk("t4_done", rsp_valid, 0);
        chk("t4_next_rdy1", req1_ready, 1);
        req0_valid = 0; req1_valid = 0;
        #1;

        // Reset at WAIT counter 10 drops the job
        req0_valid = 1; req0_data = 64'h77;
        #1;
        chk("t5_rdy0", req0_ready, 1);
        tick();                               // T+1
        req0_valid = 0;
        repeat (11) tick();                   // T+12, counter = 10
        rst = 1;
        tick();
        rst = 0;
        chk_reset_vals("t5_rst");
        seen = 0;
        repeat (40) begin
            tick();
            if (rsp_valid) seen = 1;
        end
        chk("t5_no_rsp", seen, 0);
        req1_valid = 1; req1_data = 64'hFF;
        #1;
        chk("t5_rdy1", req1_ready, 1);
        tick();
        req1_valid = 0;
        repeat (33) tick();
        chk_rsp("t5_rsp", 1, ~64'hFF);
        tick();

        // Input change after accept does not reach the core
        req0_valid = 1; req0_data = 64'h3;
        #1;
        chk("t6_rdy0", req0_ready, 1);
        tick();                               // T+1
        req0_data = 64'h4; req0_valid = 0;
        #1;
        chk("t6_din_a", core_data_in, 64'h3);
        repeat (20) tick();
        chk("t6_din_b", core_data_in, 64'h3);
        repeat (13) tick();                   // T+34
        chk_rsp("t6_rsp", 0, ~64'h3);
        chk("t6_din_c", core_data_in, 64'h3);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
